// File: rtl/uart_tx_engine.sv
// UART transmit framer in the clk26m domain.
// Takes one byte per valid/ready handshake and sends start, 8 data bits
// LSB first, an optional parity bit and one or two stop bits on utxd_o.
// Bit timing comes from an external baud generator that this block enables
// with tx_bpsen; every bit lasts exactly one baud tick interval.
module uart_tx_engine #(
  parameter int DATA_W = 8
) (
  input  logic              clk26m,
  input  logic              rst26m_,
  input  logic              tx_bpsclk,
  input  logic              txrst,
  input  logic              check,
  input  logic              parity,
  input  logic              two_stop,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_bpsen,
  output logic              utxd_o,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Parity bit for a frame: odd parity makes the total count of ones odd.
  function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic odd);
    return odd ? ~^d : ^d;
  endfunction

  // Config inputs arrive from the register-interface domain.
  logic [2:0] cfg_meta_q;
  logic [2:0] cfg_sync_q;

  // Frame state
  state_t            state_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              stop_cnt_q;
  logic              chk_q;
  logic              odd_q;
  logic              two_q;

  // Registered outputs
  logic              utxd_q;
  logic              bpsen_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;

  // Next-state helpers
  logic              accept_d;
  logic              tick_d;
  logic [CNT_W-1:0]  bit_nxt_d;
  logic              par_d;

  // ready_q is only ever high in IDLE, so it doubles as the state check.
  // An abort in the same cycle wins over the handshake.
  assign accept_d  = tx_valid && ready_q && !txrst;
  // Ticks only count while the generator is enabled, i.e. inside a frame.
  assign tick_d    = tx_bpsclk && bpsen_q;
  assign bit_nxt_d = bit_cnt_q + CNT_W'(1);
  assign par_d     = parity_bit(data_q, odd_q);

  // Two-flop synchronisers for check, parity and two_stop.
  always_ff @(posedge clk26m or negedge rst26m_) begin
    if (!rst26m_) begin
      cfg_meta_q <= 3'b000;
      cfg_sync_q <= 3'b000;
    end else begin
      cfg_meta_q <= {two_stop, parity, check};
      cfg_sync_q <= cfg_meta_q;
    end
  end

  // Capture the byte to send; held untouched until the next accept.
  always_ff @(posedge clk26m) begin
    if (accept_d) begin
      data_q <= tx_data;
    end
  end

  // Frame sequencer: every output is registered and moves one cycle after
  // the condition that causes it.
  always_ff @(posedge clk26m or negedge rst26m_) begin
    if (!rst26m_) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      chk_q      <= 1'b0;
      odd_q      <= 1'b0;
      two_q      <= 1'b0;
      utxd_q     <= 1'b1;
      bpsen_q    <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (txrst) begin
        // Abort drops the frame in flight without signalling completion.
        state_q    <= IDLE;
        bit_cnt_q  <= '0;
        stop_cnt_q <= 1'b0;
        utxd_q     <= 1'b1;
        bpsen_q    <= 1'b0;
        ready_q    <= 1'b1;
        busy_q     <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            utxd_q  <= 1'b1;
            bpsen_q <= 1'b0;
            if (accept_d) begin
              // Config is frozen here for the whole frame.
              chk_q      <= cfg_sync_q[0];
              odd_q      <= cfg_sync_q[1];
              two_q      <= cfg_sync_q[2];
              bit_cnt_q  <= '0;
              stop_cnt_q <= 1'b0;
              state_q    <= START;
              utxd_q     <= 1'b0;
              bpsen_q    <= 1'b1;
              busy_q     <= 1'b1;
              ready_q    <= 1'b0;
            end
          end
          START: begin
            if (tick_d) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
              utxd_q    <= data_q[0];
            end
          end
          DATA: begin
            if (tick_d) begin
              if (bit_cnt_q != LAST_BIT) begin
                bit_cnt_q <= bit_nxt_d;
                utxd_q    <= data_q[bit_nxt_d];
              end else if (chk_q) begin
                state_q <= PARITY;
                utxd_q  <= par_d;
              end else begin
                state_q    <= STOP;
                stop_cnt_q <= 1'b0;
                utxd_q     <= 1'b1;
              end
            end
          end
          PARITY: begin
            if (tick_d) begin
              state_q    <= STOP;
              stop_cnt_q <= 1'b0;
              utxd_q     <= 1'b1;
            end
          end
          STOP: begin
            if (tick_d) begin
              if (two_q && !stop_cnt_q) begin
                stop_cnt_q <= 1'b1;
              end else begin
                // Final stop bit has run its full interval: frame complete.
                state_q    <= IDLE;
                stop_cnt_q <= 1'b0;
                bit_cnt_q  <= '0;
                utxd_q     <= 1'b1;
                bpsen_q    <= 1'b0;
                busy_q     <= 1'b0;
                ready_q    <= 1'b1;
                done_q     <= 1'b1;
              end
            end
          end
          default: begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            utxd_q     <= 1'b1;
            bpsen_q    <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign utxd_o   = utxd_q;
  assign tx_bpsen = bpsen_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: random frames against a bit-list model of the
// UART frame format, plus directed abort, reset and back-to-back cases.
module tb_uart_tx_engine;

  logic       clk26m = 1'b0;
  logic       rst26m_ = 1'b0;
  logic       tx_bpsclk = 1'b0;
  logic       txrst = 1'b0;
  logic       check = 1'b0;
  logic       parity = 1'b0;
  logic       two_stop = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       tx_bpsen;
  logic       utxd_o;
  logic       tx_busy;
  logic       tx_done;

  int n_chk  = 0;
  int n_fail = 0;

  uart_tx_engine #(.DATA_W(8)) dut (
    .clk26m   (clk26m),
    .rst26m_  (rst26m_),
    .tx_bpsclk(tx_bpsclk),
    .txrst    (txrst),
    .check    (check),
    .parity   (parity),
    .two_stop (two_stop),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .tx_bpsen (tx_bpsen),
    .utxd_o   (utxd_o),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #19 clk26m = ~clk26m;

  // Baud generator model: divider restarts whenever tx_bpsen is low, then
  // ticks every gen_div cycles. While disabled it emits stray ticks.
  int gen_cnt = 0;
  int gen_div = 2;
  always @(negedge clk26m) begin
    if (tx_bpsen !== 1'b1) begin
      gen_cnt   = 0;
      gen_div   = $urandom_range(1, 4);
      tx_bpsclk = ($urandom_range(0, 3) == 0);
    end else begin
      gen_cnt = gen_cnt + 1;
      if (gen_cnt >= gen_div) begin
        tx_bpsclk = 1'b1;
        gen_cnt   = 0;
      end else begin
        tx_bpsclk = 1'b0;
      end
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Set config, wait for synchronisers, offer the byte and wait for accept.
  task automatic start_frame(input logic [7:0] d, input bit c, input bit p,
                             input bit ts, input bit keep);
    bit r;
    int n;
    check    = c;
    parity   = p;
    two_stop = ts;
    repeat (3) @(posedge clk26m);
    #1;
    tx_data  = d;
    tx_valid = 1'b1;
    n = 0;
    do begin
      r = tx_ready;
      @(posedge clk26m);
      #1;
      n++;
    end while (!r && n < 100);
    chk_eq("accept", r, 1);
    if (!keep) tx_valid = 1'b0;
    chk_eq("start_line", utxd_o, 0);
    chk_eq("start_bpsen", tx_bpsen, 1);
    chk_eq("start_ready", tx_ready, 0);
  endtask

  // Follow a frame from the cycle after accept to tx_done and compare the
  // bit sequence seen at each tick with the expected frame.
  task automatic run_frame(input logic [7:0] d, input bit c, input bit p,
                           input bit ts, input bit wiggle, input bit b2b);
    logic [15:0] expv;
    logic [15:0] got;
    int elen, idx, nbits, ticks, cyc;
    bit ok_en;
    expv = '0;
    expv[0] = 1'b0;
    for (int i = 0; i < 8; i++) expv[1+i] = d[i];
    idx = 9;
    if (c) begin
      expv[idx] = p ? ($countones(d) % 2 == 0) : ($countones(d) % 2 == 1);
      idx++;
    end
    expv[idx] = 1'b1;
    idx++;
    if (ts) begin
      expv[idx] = 1'b1;
      idx++;
    end
    elen = idx;

    got = '0;
    got[0] = utxd_o;
    nbits = 1;
    ticks = 0;
    cyc = 0;
    ok_en = 1;
    while (tx_done !== 1'b1 && cyc < 400) begin
      @(posedge clk26m);
      #1;
      cyc++;
      if (wiggle && cyc == 2) begin
        check    = $urandom_range(0, 1);
        parity   = $urandom_range(0, 1);
        two_stop = $urandom_range(0, 1);
      end
      if (tx_bpsclk) ticks++;
      if (tx_done !== 1'b1) begin
        if (tx_bpsclk && nbits < 16) begin
          got[nbits] = utxd_o;
          nbits++;
        end
        if (tx_bpsen !== 1'b1 || tx_busy !== 1'b1 || tx_ready !== 1'b0) ok_en = 0;
      end
    end
    chk_eq("done_seen", tx_done, 1);
    chk_eq("tick_count", ticks, elen);
    chk_eq("bit_count", nbits, elen);
    chk_eq("frame_bits", got, expv);
    chk_eq("in_frame_ctrl", ok_en, 1);
    chk_eq("end_bpsen", tx_bpsen, 0);
    chk_eq("end_ready", tx_ready, 1);
    chk_eq("end_line", utxd_o, 1);
    chk_eq("end_busy", tx_busy, 0);
    if (!b2b) begin
      @(posedge clk26m);
      #1;
      chk_eq("done_pulse", tx_done, 0);
    end
  endtask

  initial begin
    #(38 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks, n;
    bit quiet;
    logic [7:0] rd;
    bit rc, rp, rt;

    // Reset state
    repeat (3) @(posedge clk26m);
    #1;
    chk_eq("rst_line", utxd_o, 1);
    chk_eq("rst_bpsen", tx_bpsen, 0);
    chk_eq("rst_ready", tx_ready, 1);
    chk_eq("rst_busy", tx_busy, 0);
    chk_eq("rst_done", tx_done, 0);
    rst26m_ = 1'b1;
    repeat (2) @(posedge clk26m);
    #1;

    // Directed frames
    start_frame(8'h55, 0, 0, 0, 0); run_frame(8'h55, 0, 0, 0, 0, 0);
    start_frame(8'hA3, 1, 1, 0, 0); run_frame(8'hA3, 1, 1, 0, 0, 0);
    start_frame(8'h07, 1, 0, 0, 0); run_frame(8'h07, 1, 0, 0, 0, 0);
    start_frame(8'h00, 1, 0, 0, 0); run_frame(8'h00, 1, 0, 0, 0, 0);
    start_frame(8'hFF, 0, 0, 1, 0); run_frame(8'hFF, 0, 0, 1, 0, 0);

    // Back-to-back with tx_valid held
    start_frame(8'h12, 1, 1, 1, 1);
    run_frame(8'h12, 1, 1, 1, 0, 1);
    tx_data = 8'h34;
    @(posedge clk26m);
    #1;
    tx_valid = 1'b0;
    chk_eq("b2b_gap_line", utxd_o, 0);
    chk_eq("b2b_gap_bpsen", tx_bpsen, 1);
    run_frame(8'h34, 1, 1, 1, 0, 0);

    // Abort during data bit 3, with a competing tx_valid
    start_frame(8'hC3, 0, 0, 0, 0);
    ticks = 0;
    n = 0;
    while (ticks < 4 && n < 100) begin
      @(posedge clk26m);
      #1;
      n++;
      if (tx_bpsclk) ticks++;
    end
    chk_eq("abort_reach", ticks, 4);
    chk_eq("abort_bit3", utxd_o, 0);
    txrst    = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h81;
    @(posedge clk26m);
    #1;
    txrst    = 1'b0;
    tx_valid = 1'b0;
    chk_eq("abort_line", utxd_o, 1);
    chk_eq("abort_bpsen", tx_bpsen, 0);
    chk_eq("abort_ready", tx_ready, 1);
    chk_eq("abort_busy", tx_busy, 0);
    quiet = (tx_done === 1'b0);
    repeat (5) begin
      @(posedge clk26m);
      #1;
      if (tx_done !== 1'b0 || tx_bpsen !== 1'b0) quiet = 0;
    end
    chk_eq("abort_quiet", quiet, 1);
    start_frame(8'h81, 0, 0, 0, 0); run_frame(8'h81, 0, 0, 0, 0, 0);

    // Async reset mid-frame
    start_frame(8'h0F, 1, 0, 1, 0);
    #5;
    rst26m_ = 1'b0;
    #1;
    chk_eq("arst_line", utxd_o, 1);
    chk_eq("arst_bpsen", tx_bpsen, 0);
    chk_eq("arst_busy", tx_busy, 0);
    @(posedge clk26m);
    #1;
    rst26m_ = 1'b1;

    // Random frames with config wiggled mid-frame
    for (int k = 0; k < 10; k++) begin
      rd = 8'($urandom);
      rc = $urandom_range(0, 1);
      rp = $urandom_range(0, 1);
      rt = $urandom_range(0, 1);
      start_frame(rd, rc, rp, rt, 0);
      run_frame(rd, rc, rp, rt, 1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
